adt7320_temp_monitor: RTL and testbench
=======================================

// Module: adt7320_temp_monitor
// PURPOSE
//  Consumes the 16-bit temperature word from read_adt7320 (result[15:0], 13-bit mode, data in [15:3],
//  1/16 degC per LSB). Samples it periodically, discards sensor-fault words, keeps a moving average
//  over 2**AVG_LOG2 samples, tracks min/max, and raises a hysteretic over-temperature alarm for
//  board-level monitoring and readout.
// PARAMETERS
//  SAMPLE_PERIOD  100000  clk cycles between samples (1 ms at 100 MHz); must be >= 8
//  AVG_LOG2       3       log2 of moving-average depth (8 samples); legal range 1..6
//  HYST           32      alarm hysteresis, in 1/16 degC LSBs (2 degC)
// PORTS
//  clk          in   1   100 MHz system-wide master clock
//  reset        in   1   synchronous, active-high logic reset
//  result       in   16  raw ADT7320 temperature register word (from read_adt7320)
//  thresh_hi    in   13  signed alarm set threshold, 1/16 degC
//  clr_minmax   in   1   one-clk pulse: restart min/max tracking
//  temp_now     out  13  signed, last accepted sample
//  temp_avg     out  13  signed, moving average (arithmetic shift, rounds toward -inf)
//  temp_min     out  13  signed, minimum accepted sample since reset/clear
//  temp_max     out  13  signed, maximum accepted sample since reset/clear
//  avg_valid    out  1   high once the buffer holds 2**AVG_LOG2 samples
//  minmax_valid out  1   high once min/max hold at least one sample
//  sample_stb   out  1   one-clk pulse when all outputs have updated for a new sample
//  over_temp    out  1   alarm, hysteretic
//  sensor_fault out  1   high while the most recent raw word was 16'hFFFF (absent chip; DOUT floats high)
// BEHAVIOUR
//  Reset: all outputs 0, buffer entries 0, running sum 0, fill count 0, timer 0, FSM IDLE.
//  Timer: counts 0..SAMPLE_PERIOD-1 and wraps; tick at count==SAMPLE_PERIOD-1 starts a sample.
//  FSM (one state per clk):
//   IDLE    -> LATCH on tick; else stay.
//   LATCH   raw<=result. If raw==16'hFFFF: sensor_fault<=1, -> IDLE (no other update, no stb).
//           Else sensor_fault<=0, smp<=result[15:3] (bits [2:0] ignored), -> UPDATE.
//   UPDATE  sum<=sum+smp-buf[ptr]; buf[ptr]<=smp; ptr<=ptr+1 (wraps mod 2**AVG_LOG2);
//           fill<=fill+1, saturating at 2**AVG_LOG2; -> COMPARE.
//   COMPARE temp_now<=smp. If fill==2**AVG_LOG2: temp_avg<=sum>>>AVG_LOG2, avg_valid<=1.
//           Update min/max, then -> DONE.
//   DONE    sample_stb=1 for this clk; alarm evaluated on the new temp_avg; -> IDLE.
//  Latency: tick to sample_stb = 4 clk. The tick cannot recur mid-sequence (SAMPLE_PERIOD>=8).
//  Widths: sum is signed, 13+AVG_LOG2 bits, and cannot overflow. All compares are signed.
//  Min/max: if !minmax_valid, min=max=smp and minmax_valid<=1. Otherwise min<=smp if smp<min,
//   max<=smp if smp>max. clr_minmax in any state clears minmax_valid. If clr_minmax coincides
//   with COMPARE, the clear wins and that sample is not tracked; the next sample re-seeds.
//  Alarm (only while avg_valid): set when temp_avg >= thresh_hi. Clear when
//   temp_avg < thresh_hi - HYST, with the difference computed at 14 bits signed so it cannot wrap.
//   Otherwise hold. thresh_hi may change at any time and takes effect at the next DONE.
//  Fault words do not disturb the average, fill, min/max, or alarm. These keep their last values.
//  reset mid-sequence: returns to IDLE at once and everything reverts to reset values.
// STRUCTURE
//  adt7320_defs.vh (shared with read_adt7320 users): TEMP_W=13, TEMP_LSB_SHIFT=3,
//   FAULT_WORD=16'hFFFF, FSM state localparams.
//  Sub-module temp_avg_buffer: circular buffer, ptr, fill count, running sum.
//   Inputs: smp, wr_en. Outputs: sum, full.
//  The top level keeps the timer, FSM, min/max, alarm, and output registers.
// TESTING (SAMPLE_PERIOD=16, AVG_LOG2=3, HYST=32, thresh_hi=13'sd480 = 30 degC)
//  1 Constant result=16'h0C80 (25 degC): avg_valid rises at the 8th sample_stb, temp_avg=400,
//    temp_min=temp_max=400, over_temp=0.
//  2 Negative: result=16'hFB00 (-10 degC), 8 samples -> temp_avg=-160 (13'h1F60); result bits [2:0]=3'b111
//    change nothing.
//  3 Alarm hysteresis: average ramps 400->480 -> over_temp=1 at the DONE where avg=480;
//    avg=449 keeps 1; avg=447 clears it.
//  4 Fault: result=16'hFFFF for 3 ticks -> sensor_fault=1, no sample_stb, all other outputs held;
//    then 16'h0C80 -> sensor_fault=0 and the stb resumes.
//  5 Min/max: samples 400,320,560 -> min=320, max=560; clr_minmax during COMPARE of the next 400
//    -> minmax_valid=0; the following 400 gives min=max=400.
//  6 Reset asserted in UPDATE -> all outputs 0, fill=0; avg_valid needs 8 fresh samples.

Source files
------------

// File: rtl/adt7320_defs_pkg.sv
// Shared definitions for ADT7320 temperature-word consumers: word layout,
// fault marker and the monitor's sequencing states.
package adt7320_defs_pkg;

    localparam int          TEMP_W         = 13;
    localparam int          TEMP_LSB_SHIFT = 3;
    localparam logic [15:0] FAULT_WORD     = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LATCH   = 3'd1,
        ST_UPDATE  = 3'd2,
        ST_COMPARE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/temp_avg_buffer.sv
// Circular sample buffer with a running sum; the sum is kept exact by
// subtracting the entry being overwritten.
module temp_avg_buffer
    import adt7320_defs_pkg::*;
#(
    parameter int AVG_LOG2 = 3
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic signed [TEMP_W-1:0]          smp,
    input  logic                              wr_en,
    output logic signed [TEMP_W+AVG_LOG2-1:0] sum,
    output logic                              full
);

    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SW    = TEMP_W + AVG_LOG2;

    logic signed [TEMP_W-1:0] buf_mem [DEPTH];
    logic [AVG_LOG2-1:0]      ptr;
    logic [AVG_LOG2:0]        fill;

    assign full = (fill == (AVG_LOG2+1)'(DEPTH));

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_mem[i] <= '0;
            end
            ptr  <= '0;
            fill <= '0;
            sum  <= '0;
        end else if (wr_en) begin
            sum          <= sum + SW'(smp) - SW'(buf_mem[ptr]);
            buf_mem[ptr] <= smp;
            ptr          <= ptr + 1'b1;
            if (!full) begin
                fill <= fill + 1'b1;
            end
        end
    end

endmodule

// File: rtl/adt7320_temp_monitor.sv
// Periodic ADT7320 sampler: fault filtering, moving average, min/max tracking
// and a hysteretic over-temperature alarm evaluated on the average.
module adt7320_temp_monitor
    import adt7320_defs_pkg::*;
#(
    parameter int SAMPLE_PERIOD = 100000,
    parameter int AVG_LOG2      = 3,
    parameter int HYST          = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [15:0]              result,
    input  logic signed [TEMP_W-1:0] thresh_hi,
    input  logic                     clr_minmax,
    output logic signed [TEMP_W-1:0] temp_now,
    output logic signed [TEMP_W-1:0] temp_avg,
    output logic signed [TEMP_W-1:0] temp_min,
    output logic signed [TEMP_W-1:0] temp_max,
    output logic                     avg_valid,
    output logic                     minmax_valid,
    output logic                     sample_stb,
    output logic                     over_temp,
    output logic                     sensor_fault,
    output state_t                   dbg_state
);

    localparam int TW = $clog2(SAMPLE_PERIOD);
    localparam int SW = TEMP_W + AVG_LOG2;

    state_t                   state, next_state;
    logic [TW-1:0]            timer;
    logic                     tick;
    logic signed [TEMP_W-1:0] smp;
    logic signed [SW-1:0]     sum;
    logic                     full;
    logic signed [TEMP_W:0]   thr_lo;
    logic signed [TEMP_W:0]   avg_ext;

    assign tick      = (timer == TW'(SAMPLE_PERIOD - 1));
    assign dbg_state = state;
    // 14-bit difference so a threshold near the negative limit cannot wrap.
    assign thr_lo    = $signed({thresh_hi[TEMP_W-1], thresh_hi}) - $signed((TEMP_W+1)'(HYST));
    assign avg_ext   = $signed({temp_avg[TEMP_W-1], temp_avg});

    always_ff @(posedge clk) begin
        if (reset || tick) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        sample_stb = 1'b0;
        case (state)
            ST_IDLE:    if (tick) next_state = ST_LATCH;
            ST_LATCH:   next_state = (result == FAULT_WORD) ? ST_IDLE : ST_UPDATE;
            ST_UPDATE:  next_state = ST_COMPARE;
            ST_COMPARE: next_state = ST_DONE;
            ST_DONE: begin
                sample_stb = 1'b1;
                next_state = ST_IDLE;
            end
            default:    next_state = ST_IDLE;
        endcase
    end

    temp_avg_buffer #(
        .AVG_LOG2(AVG_LOG2)
    ) u_avg_buffer (
        .clk   (clk),
        .reset (reset),
        .smp   (smp),
        .wr_en (state == ST_UPDATE),
        .sum   (sum),
        .full  (full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            smp          <= '0;
            sensor_fault <= 1'b0;
            temp_now     <= '0;
            temp_avg     <= '0;
            temp_min     <= '0;
            temp_max     <= '0;
            avg_valid    <= 1'b0;
            minmax_valid <= 1'b0;
            over_temp    <= 1'b0;
        end else begin
            case (state)
                ST_LATCH: begin
                    if (result == FAULT_WORD) begin
                        sensor_fault <= 1'b1;
                    end else begin
                        sensor_fault <= 1'b0;
                        smp          <= result[15:TEMP_LSB_SHIFT];
                    end
                end
                ST_COMPARE: begin
                    temp_now <= smp;
                    if (full) begin
                        temp_avg  <= TEMP_W'(sum >>> AVG_LOG2);
                        avg_valid <= 1'b1;
                    end
                    if (!clr_minmax) begin
                        if (!minmax_valid) begin
                            temp_min     <= smp;
                            temp_max     <= smp;
                            minmax_valid <= 1'b1;
                        end else begin
                            if (smp < temp_min) temp_min <= smp;
                            if (smp > temp_max) temp_max <= smp;
                        end
                    end
                end
                ST_DONE: begin
                    if (avg_valid) begin
                        if (temp_avg >= thresh_hi) begin
                            over_temp <= 1'b1;
                        end else if (avg_ext < thr_lo) begin
                            over_temp <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
            // A clear always wins, including over a seed in COMPARE.
            if (clr_minmax) begin
                minmax_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_adt7320_temp_monitor.sv
// Directed bench for adt7320_temp_monitor: vector table of samples with
// hand-computed averages/min/max/alarm, plus fault, clear and reset sequences.
module tb_adt7320_temp_monitor;
    import adt7320_defs_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] result = 16'h0C80;
    logic [12:0] thresh_hi = 13'd480;
    logic        clr_minmax = 1'b0;
    logic [12:0] temp_now, temp_avg, temp_min, temp_max;
    logic        avg_valid, minmax_valid, sample_stb, over_temp, sensor_fault;
    state_t      dbg_state;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    adt7320_temp_monitor #(
        .SAMPLE_PERIOD(16),
        .AVG_LOG2     (3),
        .HYST         (32)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .result       (result),
        .thresh_hi    (thresh_hi),
        .clr_minmax   (clr_minmax),
        .temp_now     (temp_now),
        .temp_avg     (temp_avg),
        .temp_min     (temp_min),
        .temp_max     (temp_max),
        .avg_valid    (avg_valid),
        .minmax_valid (minmax_valid),
        .sample_stb   (sample_stb),
        .over_temp    (over_temp),
        .sensor_fault (sensor_fault),
        .dbg_state    (dbg_state)
    );

    typedef struct {
        bit          clr;
        logic [15:0] result;
        int          now;
        int          avg;
        bit          avg_valid;
        int          mn;
        int          mx;
        bit          over;
    } vec_t;

    vec_t vecs [23];

    task automatic check(input string name, input logic [12:0] act, input int exp);
        logic [12:0] e;
        e = exp[12:0];
        checks++;
        if (act !== e) begin
            failures++;
            $display("FAIL %s: got %0d (0x%h) want %0d (0x%h)", name, $signed(act), act, $signed(e), e);
        end
    endtask

    task automatic wait_stb(output bit got, output int n);
        got = 1'b0;
        n = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (sample_stb) begin
                got = 1'b1;
                n = i + 1;
                break;
            end
        end
    endtask

    task automatic wait_state(input state_t s, output bit got);
        got = 1'b0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (dbg_state == s) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        bit got;
        int n;
        if (v.clr) begin
            clr_minmax = 1'b1;
            @(negedge clk);
            clr_minmax = 1'b0;
        end
        result = v.result;
        wait_stb(got, n);
        check($sformatf("v%0d_stb_seen", idx), 13'(got), 1);
        check($sformatf("v%0d_temp_now", idx), temp_now, v.now);
        check($sformatf("v%0d_temp_avg", idx), temp_avg, v.avg);
        check($sformatf("v%0d_avg_valid", idx), 13'(avg_valid), int'(v.avg_valid));
        check($sformatf("v%0d_temp_min", idx), temp_min, v.mn);
        check($sformatf("v%0d_temp_max", idx), temp_max, v.mx);
        check($sformatf("v%0d_minmax_valid", idx), 13'(minmax_valid), 1);
        @(negedge clk);
        check($sformatf("v%0d_stb_one_clk", idx), 13'(sample_stb), 0);
        check($sformatf("v%0d_over_temp", idx), 13'(over_temp), int'(v.over));
    endtask

    initial begin
        bit got;
        int n;
        vec_t v;

        // Constant 25 degC: average valid on the 8th sample.
        for (int i = 0; i < 7; i++) vecs[i] = '{0, 16'h0C80, 400, 0, 0, 400, 400, 0};
        vecs[7]  = '{0, 16'h0C80, 400, 400, 1, 400, 400, 0};
        // Alarm ramp: 440, 480 (set), 449 (hold), 447 (clear).
        vecs[8]  = '{0, 16'h1680, 720, 440, 1, 400, 720, 0};
        vecs[9]  = '{0, 16'h1680, 720, 480, 1, 400, 720, 1};
        vecs[10] = '{0, 16'h04C0, 152, 449, 1, 152, 720, 1};
        vecs[11] = '{0, 16'h0C00, 384, 447, 1, 152, 720, 0};
        // -10 degC, low bits set on alternate words.
        vecs[12] = '{0, 16'hFB00, -160, 377, 1, -160, 720, 0};
        vecs[13] = '{0, 16'hFB07, -160, 307, 1, -160, 720, 0};
        vecs[14] = '{0, 16'hFB00, -160, 237, 1, -160, 720, 0};
        vecs[15] = '{0, 16'hFB07, -160, 167, 1, -160, 720, 0};
        vecs[16] = '{0, 16'hFB00, -160, 57, 1, -160, 720, 0};
        vecs[17] = '{0, 16'hFB07, -160, -53, 1, -160, 720, 0};
        vecs[18] = '{0, 16'hFB00, -160, -92, 1, -160, 720, 0};
        vecs[19] = '{0, 16'hFB07, -160, -160, 1, -160, 720, 0};
        // Clear in IDLE, then 400, 320, 560.
        vecs[20] = '{1, 16'h0C80, 400, -90, 1, 400, 400, 0};
        vecs[21] = '{0, 16'h0A00, 320, -30, 1, 320, 400, 0};
        vecs[22] = '{0, 16'h1180, 560, 60, 1, 320, 560, 0};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_temp_now", temp_now, 0);
        check("rst_temp_avg", temp_avg, 0);
        check("rst_avg_valid", 13'(avg_valid), 0);
        check("rst_minmax_valid", 13'(minmax_valid), 0);
        check("rst_over_temp", 13'(over_temp), 0);
        check("rst_sample_stb", 13'(sample_stb), 0);
        check("rst_state", 13'(dbg_state), int'(ST_IDLE));

        for (int i = 0; i < 23; i++) apply_vec(vecs[i], i);

        // Clear coinciding with COMPARE: sample not tracked.
        result = 16'h0C80;
        wait_state(ST_COMPARE, got);
        check("clr_cmp_state_seen", 13'(got), 1);
        clr_minmax = 1'b1;
        @(negedge clk);
        clr_minmax = 1'b0;
        check("clr_cmp_stb", 13'(sample_stb), 1);
        check("clr_cmp_minmax_valid", 13'(minmax_valid), 0);
        check("clr_cmp_temp_now", temp_now, 400);
        check("clr_cmp_temp_avg", temp_avg, 130);
        @(negedge clk);
        v = '{0, 16'h0C80, 400, 200, 1, 400, 400, 0};
        apply_vec(v, 100);

        // Sensor absent for three ticks.
        result = 16'hFFFF;
        for (int k = 0; k < 3; k++) begin
            wait_stb(got, n);
            check($sformatf("fault%0d_no_stb", k), 13'(got), 0);
            check($sformatf("fault%0d_flag", k), 13'(sensor_fault), 1);
        end
        check("fault_hold_now", temp_now, 400);
        check("fault_hold_avg", temp_avg, 200);
        check("fault_hold_min", temp_min, 400);
        check("fault_hold_max", temp_max, 400);
        check("fault_hold_avg_valid", 13'(avg_valid), 1);
        check("fault_hold_over", 13'(over_temp), 0);
        result = 16'h0C80;
        wait_stb(got, n);
        check("fault_recover_stb", 13'(got), 1);
        check("fault_recover_flag", 13'(sensor_fault), 0);
        check("fault_recover_avg", temp_avg, 270);
        @(negedge clk);

        // Reset in UPDATE.
        wait_state(ST_UPDATE, got);
        check("rst_upd_state_seen", 13'(got), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_upd_state", 13'(dbg_state), int'(ST_IDLE));
        check("rst_upd_temp_now", temp_now, 0);
        check("rst_upd_temp_avg", temp_avg, 0);
        check("rst_upd_min", temp_min, 0);
        check("rst_upd_max", temp_max, 0);
        check("rst_upd_avg_valid", 13'(avg_valid), 0);
        check("rst_upd_minmax_valid", 13'(minmax_valid), 0);
        for (int i = 0; i < 8; i++) begin
            wait_stb(got, n);
            check($sformatf("refill%0d_stb_seen", i), 13'(got), 1);
            if (i == 0) check("refill_latency", 13'(n), 19);
            check($sformatf("refill%0d_avg_valid", i), 13'(avg_valid), (i == 7) ? 1 : 0);
            check($sformatf("refill%0d_temp_avg", i), temp_avg, (i == 7) ? 400 : 0);
            check($sformatf("refill%0d_temp_now", i), temp_now, 400);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
